// File: rtl/seg_serial_rx_pkg.sv
// Shared types and constants for the serial display-protocol receiver.
// Frame widths match the 7-segment (8 digits x 8 segments) and LED chains.
package seg_serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rx_state_t;

    localparam int SEG_FRAME_W = 64;
    localparam int LED_FRAME_W = 16;

endpackage

// File: rtl/seg_serial_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous wire, with a delayed level
// and a single-cycle rise strobe derived from the synchronized value.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/seg_serial_rx.sv
// Deserializer for the shift-clock / data / latch / clear display protocol.
// Oversamples the wires with clk and publishes each well-formed MSB-first frame.
//
// state | meaning
// IDLE  | no bits held, bit_cnt = 0
// SHIFT | collecting bits, 1 <= bit_cnt <= FRAME_W+1
// HOLD  | frame just latched, waiting for s_pen to drop
module seg_serial_rx
    import seg_serial_rx_pkg::*;
#(
    parameter int FRAME_W     = SEG_FRAME_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          RSTN,
    input  logic                          s_clk,
    input  logic                          s_sout,
    input  logic                          s_pen,
    input  logic                          s_clrn,
    output logic [FRAME_W-1:0]            frame,
    output logic                          frame_valid,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic                          err_len,
    output logic                          err_sticky,
    output logic                          busy,
    output logic [$clog2(FRAME_W+2)-1:0]  bit_cnt
);

    localparam int BC_W = $clog2(FRAME_W + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRAME_W);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(FRAME_W + 1);

    logic clk_level_unused;
    logic clk_rise;
    logic pen_level;
    logic pen_rise;
    logic clrn_level;
    logic clrn_rise_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk   (clk),
        .rstn  (RSTN),
        .din   (s_clk),
        .level (clk_level_unused),
        .rise  (clk_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pen (
        .clk   (clk),
        .rstn  (RSTN),
        .din   (s_pen),
        .level (pen_level),
        .rise  (pen_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clrn (
        .clk   (clk),
        .rstn  (RSTN),
        .din   (s_clrn),
        .level (clrn_level),
        .rise  (clrn_rise_unused)
    );

    // Data gets the same depth as s_clk so the sampled bit lines up with its rise.
    logic [SYNC_STAGES-1:0] sout_chain;
    logic                   sout_level;

    always_ff @(posedge clk) begin
        if (!RSTN) sout_chain <= '0;
        else       sout_chain <= {sout_chain[SYNC_STAGES-2:0], s_sout};
    end

    assign sout_level = sout_chain[SYNC_STAGES-1];

    rx_state_t          state, state_nxt;
    logic [FRAME_W-1:0] shreg, shreg_nxt;
    logic [BC_W-1:0]    bit_cnt_nxt;
    logic [FRAME_W-1:0] frame_nxt;
    logic [CNT_W-1:0]   frame_cnt_nxt;
    logic               valid_nxt;
    logic               err_nxt;
    logic               sticky_nxt;

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
            err_len     <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            frame       <= frame_nxt;
            frame_cnt   <= frame_cnt_nxt;
            frame_valid <= valid_nxt;
            err_len     <= err_nxt;
            err_sticky  <= sticky_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        frame_nxt     = frame;
        frame_cnt_nxt = frame_cnt;
        valid_nxt     = 1'b0;
        err_nxt       = 1'b0;
        sticky_nxt    = err_sticky;

        if (!clrn_level) begin
            state_nxt   = IDLE;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
        end else begin
            if (clk_rise) begin
                shreg_nxt   = {shreg[FRAME_W-2:0], sout_level};
                bit_cnt_nxt = (bit_cnt == BC_MAX) ? BC_MAX : bit_cnt + 1'b1;
                state_nxt   = SHIFT;
            end

            // Latch decision sees the count after any same-cycle shift.
            if (pen_rise && state_nxt == SHIFT) begin
                if (bit_cnt_nxt == BC_FULL) begin
                    frame_nxt     = shreg_nxt;
                    frame_cnt_nxt = frame_cnt + 1'b1;
                    valid_nxt     = 1'b1;
                end else begin
                    err_nxt    = 1'b1;
                    sticky_nxt = 1'b1;
                end
                bit_cnt_nxt = '0;
                state_nxt   = HOLD;
            end else if (state == HOLD && !clk_rise && !pen_level) begin
                state_nxt = IDLE;
            end
        end
    end

    assign busy = (bit_cnt != '0);

endmodule

// File: tb/tb_seg_serial_rx.sv
// Randomized bench for seg_serial_rx: a queue-based reference model predicts
// each latch outcome and an independent monitor checks every DUT pulse.
module tb_seg_serial_rx;

    localparam int FW = 64;
    localparam int SS = 2;
    localparam int CW = 16;
    localparam int BW = $clog2(FW + 2);

    logic          clk    = 1'b0;
    logic          RSTN   = 1'b0;
    logic          s_clk  = 1'b0;
    logic          s_sout = 1'b0;
    logic          s_pen  = 1'b0;
    logic          s_clrn = 1'b1;
    logic [FW-1:0] frame;
    logic          frame_valid;
    logic [CW-1:0] frame_cnt;
    logic          err_len;
    logic          err_sticky;
    logic          busy;
    logic [BW-1:0] bit_cnt;

    seg_serial_rx #(.FRAME_W(FW), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk         (clk),
        .RSTN        (RSTN),
        .s_clk       (s_clk),
        .s_sout      (s_sout),
        .s_pen       (s_pen),
        .s_clrn      (s_clrn),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt),
        .err_len     (err_len),
        .err_sticky  (err_sticky),
        .busy        (busy),
        .bit_cnt     (bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [FW-1:0] frame;
        logic [CW-1:0] cnt;
        bit            sticky;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   monitor_on = 1'b0;

    // Reference model: the bits seen since the last latch/clear, plus published state.
    bit            model_bits[$];
    logic [FW-1:0] m_frame  = '0;
    logic [CW-1:0] m_cnt    = '0;
    bit            m_sticky = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_latch();
        exp_t          e;
        logic [FW-1:0] v;
        if (model_bits.size() == 0) return;
        if (model_bits.size() == FW) begin
            v = '0;
            for (int i = 0; i < FW; i++) v[FW-1-i] = model_bits[i];
            m_frame  = v;
            m_cnt    = m_cnt + 1'b1;
            e.is_err = 1'b0;
        end else begin
            m_sticky = 1'b1;
            e.is_err = 1'b1;
        end
        e.frame  = m_frame;
        e.cnt    = m_cnt;
        e.sticky = m_sticky;
        exp_q.push_back(e);
        model_bits.delete();
    endtask

    task automatic send_bit(input bit b, input bit pen_too);
        int lo;
        int hi;
        lo = $urandom_range(3, 5);
        hi = $urandom_range(3, 5);
        s_sout = b;
        repeat (lo) @(negedge clk);
        s_clk = 1'b1;
        model_bits.push_back(b);
        if (pen_too) begin
            s_pen = 1'b1;
            model_latch();
        end
        repeat (hi) @(negedge clk);
        s_clk = 1'b0;
        s_pen = 1'b0;
    endtask

    task automatic send_bits(input logic [127:0] d, input int n, input bit pen_last);
        for (int i = 0; i < n; i++) send_bit(d[n-1-i], pen_last && (i == n - 1));
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_pen();
        repeat (2) @(negedge clk);
        s_pen = 1'b1;
        model_latch();
        repeat (4) @(negedge clk);
        s_pen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clrn();
        s_clrn = 1'b0;
        model_bits.delete();
        repeat (4) @(negedge clk);
        s_clrn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        monitor_on = 1'b0;
        RSTN = 1'b0;
        repeat (3) @(negedge clk);
        RSTN = 1'b1;
        model_bits.delete();
        exp_q.delete();
        m_frame  = '0;
        m_cnt    = '0;
        m_sticky = 1'b0;
        @(negedge clk);
        monitor_on = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (monitor_on && (frame_valid || err_len)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse valid=%b err_len=%b expected none", frame_valid, err_len);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_err_len", 64'(err_len), 64'(e.is_err));
                    check("pulse_frame_valid", 64'(frame_valid), 64'(!e.is_err));
                    check("pulse_frame", frame, e.frame);
                    check("pulse_frame_cnt", 64'(frame_cnt), 64'(e.cnt));
                    check("pulse_err_sticky", 64'(err_sticky), 64'(e.sticky));
                end
            end
        end
    end

    initial begin : stimulus
        logic [127:0] d;
        int           n;

        // Reset
        RSTN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_frame", frame, 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_cnt", 64'(frame_cnt), 64'd0);
        check("rst_err_len", 64'(err_len), 64'd0);
        check("rst_sticky", 64'(err_sticky), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        RSTN = 1'b1;
        @(negedge clk);
        monitor_on = 1'b1;

        // Nominal frame with a latency check on the latch strobe
        send_bits(128'hDEADBEEF_01234567, 64, 1'b0);
        check("bit_cnt_full", 64'(bit_cnt), 64'd64);
        s_pen = 1'b1;
        model_latch();
        @(negedge clk);
        @(negedge clk);
        check("lat_early", 64'(frame_valid), 64'd0);
        @(negedge clk);
        check("lat_on_time", 64'(frame_valid), 64'd1);
        @(negedge clk);
        check("valid_one_cycle", 64'(frame_valid), 64'd0);
        repeat (3) @(negedge clk);
        s_pen = 1'b0;
        repeat (4) @(negedge clk);
        wait_drain("drain_nominal");
        check("nominal_frame", frame, 64'hDEADBEEF_01234567);
        check("nominal_cnt", 64'(frame_cnt), 64'd1);
        check("nominal_sticky", 64'(err_sticky), 64'd0);
        check("nominal_busy", 64'(busy), 64'd0);

        // Short and overlong frames; idle refresh in between is ignored
        send_bits({$urandom, $urandom, $urandom, $urandom}, 63, 1'b0);
        pulse_pen();
        pulse_pen();
        send_bits({$urandom, $urandom, $urandom, $urandom}, 66, 1'b0);
        check("bit_cnt_saturate", 64'(bit_cnt), 64'd65);
        check("busy_overlong", 64'(busy), 64'd1);
        pulse_pen();
        wait_drain("drain_len_err");
        check("len_err_sticky", 64'(err_sticky), 64'd1);
        check("len_err_frame_kept", frame, 64'hDEADBEEF_01234567);
        check("len_err_cnt_kept", 64'(frame_cnt), 64'd1);

        // Clear mid-frame discards partial bits
        send_bits({$urandom, $urandom, $urandom, $urandom}, 20, 1'b0);
        check("bit_cnt_20", 64'(bit_cnt), 64'd20);
        pulse_clrn();
        check("clrn_bit_cnt", 64'(bit_cnt), 64'd0);
        check("clrn_busy", 64'(busy), 64'd0);
        send_bits(128'h0F0F_F0F0_AAAA_5555, 64, 1'b0);
        pulse_pen();
        wait_drain("drain_clrn");
        check("clrn_frame", frame, 64'h0F0F_F0F0_AAAA_5555);
        check("clrn_cnt", 64'(frame_cnt), 64'd2);

        // Last shift clock and latch rise together
        d = {64'd0, $urandom, $urandom};
        send_bits(d, 64, 1'b1);
        wait_drain("drain_same_edge");
        check("same_edge_frame", frame, d[63:0]);
        check("same_edge_cnt", 64'(frame_cnt), 64'd3);

        // Reset mid-frame, then a clean frame
        send_bits({$urandom, $urandom, $urandom, $urandom}, 30, 1'b0);
        do_reset();
        check("midrst_bit_cnt", 64'(bit_cnt), 64'd0);
        check("midrst_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_sticky", 64'(err_sticky), 64'd0);
        d = {64'd0, $urandom, $urandom};
        send_bits(d, 64, 1'b0);
        pulse_pen();
        wait_drain("drain_midrst");
        check("midrst_frame", frame, d[63:0]);
        check("midrst_cnt_after", 64'(frame_cnt), 64'd1);
        check("midrst_err", 64'(err_sticky), 64'd0);

        // Randomized frames of mostly correct, sometimes wrong length
        for (int k = 0; k < 12; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            n = ($urandom_range(0, 9) < 7) ? FW : int'($urandom_range(1, 70));
            if (n == FW && $urandom_range(0, 3) == 0) begin
                send_bits(d, n, 1'b1);
            end else begin
                send_bits(d, n, 1'b0);
                pulse_pen();
            end
            if ($urandom_range(0, 3) == 0) pulse_pen();
            wait_drain("drain_random");
        end

        check("final_cnt", 64'(frame_cnt), 64'(m_cnt));
        check("final_frame", frame, m_frame);
        check("final_sticky", 64'(err_sticky), 64'(m_sticky));
        check("final_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_serial_rx.md
Name: seg_serial_rx

Overview:
- Receiver for the serial shift-register display protocol driven by the 7-segment and LED drivers: `*_clk` shift clock, `*_sout` data, `*_PEN` latch/refresh enable, `*_clrn` clear.
- Oversamples the four wires with the system clock and deserializes MSB-first frames.
- Delivers each completed frame as a parallel word with a one-cycle valid strobe.
- Used as an on-chip loopback monitor and as the reference checker in display-path benches.

Parameters:
- FRAME_W, 64: bits per frame (64 for 8 digits x 8 segments; 16 for the LED chain).
- SYNC_STAGES, 2: synchronizer flops per input wire (min 2).
- CNT_W, 16: width of the frame counter.

Ports:
- clk  in  1  system clock (100 MHz).
- RSTN  in  1  reset; synchronous to clk, active-low.
- s_clk  in  1  serial shift clock; asynchronous to clk.
- s_sout  in  1  serial data; sampled on s_clk rising edge.
- s_pen  in  1  latch enable; a rising edge ends the frame.
- s_clrn  in  1  active-low clear of the receive shift register.
- frame  out  FRAME_W  last accepted frame; first-received bit is the MSB.
- frame_valid  out  1  one-cycle pulse when frame updates.
- frame_cnt  out  CNT_W  count of accepted frames; wraps modulo 2^CNT_W.
- err_len  out  1  one-cycle pulse on a latch with bad bit count.
- err_sticky  out  1  set by err_len; cleared only by RSTN.
- busy  out  1  high while at least one bit is held and not yet latched.
- bit_cnt  out  clog2(FRAME_W+2)  bits received in the current frame; saturates at FRAME_W+1.

Behaviour:
- Reset: RSTN low at a clk edge zeroes frame, frame_valid, frame_cnt, err_len, err_sticky, busy, bit_cnt, the shift register and the sync flops. State returns to IDLE. Reset applies mid-frame as well, and all partial data is discarded.
- Synchronization and edge detection:
  - s_clk, s_pen and s_clrn each pass through SYNC_STAGES flops plus one previous-value flop. A rise is detected when the synced value is 1 and the previous value is 0.
  - s_sout passes through the same SYNC_STAGES delay so that it stays aligned with s_clk.
- Input timing requirement: s_clk high and low phases each last ≥ 3 clk cycles. s_sout is stable from 1 clk before to 1 clk after each s_clk rise. Violations are not detected.
- States:
  - IDLE: bit_cnt = 0.
  - SHIFT: 1 ≤ bit_cnt ≤ FRAME_W+1.
  - HOLD: a frame has just been latched; waits for s_pen to fall.
- Transitions:
  - IDLE → SHIFT on an s_clk rise.
  - SHIFT → HOLD on an s_pen rise.
  - HOLD → IDLE when synced s_pen = 0.
  - HOLD → SHIFT if an s_clk rise arrives in HOLD; the bit is accepted and bit_cnt = 1.
- Shift: on an s_clk rise, shreg = {shreg[FRAME_W-2:0], sout_sync}. bit_cnt increments and saturates at FRAME_W+1.
- Latch: on an s_pen rise in SHIFT:
  - bit_cnt == FRAME_W: frame <= shreg, frame_valid = 1 for one cycle, frame_cnt + 1.
  - bit_cnt ≠ FRAME_W (short or overlong frame): frame is unchanged, err_len = 1 for one cycle, err_sticky <= 1.
  - In both cases bit_cnt then clears to 0.
- An s_pen rise in IDLE (refresh with no data) is ignored: no valid, no error.
- Simultaneous events, in priority order:
  1. s_clrn synced low beats everything: shreg and bit_cnt clear, state goes to IDLE, no pulse.
  2. s_clk rise and s_pen rise in the same cycle: the shift is applied first, and the latch decision uses the post-shift bit_cnt.
- Latency: frame_valid and err_len go high in the cycle after clk edge number SYNC_STAGES, counting the edge that first samples s_pen high as edge 0.
- busy = (bit_cnt ≠ 0).

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2;
  - default frame widths: SEG_FRAME_W = 64, LED_FRAME_W = 16.
- One sub-module, sync_edge: SYNC_STAGES synchronizer with rise-detect output and delayed-level output. It is instantiated three times (s_clk, s_pen, s_clrn); s_sout uses the level path only.

Test Plan:
- RSTN low 3 cycles, then high → all outputs 0, busy = 0, frame_cnt = 0.
- Shift 64 bits of 64'hDEADBEEF_01234567 MSB-first, then pulse s_pen → frame = 64'hDEADBEEF_01234567, frame_valid high exactly 1 cycle, frame_cnt = 1, err_sticky = 0.
- Shift 63 bits, then s_pen; separately shift 66 bits, then s_pen → err_len pulses twice, err_sticky = 1, frame keeps its prior value, frame_cnt unchanged.
- Shift 20 bits, pulse s_clrn low, then shift 64 bits of 64'h0F0F_F0F0_AAAA_5555 and s_pen → accepted frame equals that value, no error.
- 64th s_clk rise and s_pen rise on the same clk edge → frame accepted, frame_valid pulses.
- RSTN asserted after 30 bits, released, full 64-bit frame sent → frame_cnt = 1 with correct data, no err_len.
